tlb_search_arbiter: RTL and testbench

- Shares the single TLB search port between three requesters: CP0 TLBP (req 0), instruction fetch (req 1) and data memory (req 2).
- Holds one registered search result until the owning requester accepts it.
- Blocks new lookups while a TLB write (TLBWI/TLBWR) is in progress, so no requester receives a stale mapping.
- Sits between the core pipeline stages and the TLB array in cpu_core; uses the tlb_params search_request_t and search_result_t types.

---
 rtl/tlb_search_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_tlb_search_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_search_arbiter.sv
// ---------------------------------------------------------------------------
// tlb_search_arbiter
//
// Lets three requesters share the single TLB search port: CP0 TLBP (req 0),
// instruction fetch (req 1) and data memory (req 2). Every accepted lookup
// goes to the combinational TLB in the same cycle. The result is registered
// and held for its owner until that owner accepts it. Lookups are blocked
// while a TLB write is in progress, so no requester can see a stale mapping.
//
// Ports
//   clock           core clock, all state updates on posedge
//   reset           asynchronous, active-high reset
//   req_valid[2:0]  per-requester lookup request valid
//   req_ready[2:0]  per-requester grant (accepted when valid && ready)
//   req[2:0]        per-requester search_request_t {vpn[18:0], odd, asid[7:0]}
//   resp_valid[2:0] held result valid for its owner (one-hot or zero)
//   resp_ready[2:0] per-requester result accept
//   resp            held search_result_t {found, index, entry[24:0]}
//   flush           pipeline flush; kills inst/data requests and results
//   tlb_write_busy  a TLB write is being performed this cycle
//   tlb_search      search request driven to the TLB
//   tlb_result      combinational TLB result for tlb_search
// ---------------------------------------------------------------------------
module tlb_search_arbiter #(
  parameter int TLB_NUM = 16,
  parameter int REQ_NUM = 3,
  localparam int IDX_W = $clog2(TLB_NUM),
  localparam int REQ_W = 28,
  localparam int RES_W = 1 + IDX_W + 25
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [REQ_NUM-1:0]              req_valid,
  output logic [REQ_NUM-1:0]              req_ready,
  input  logic [REQ_NUM-1:0][REQ_W-1:0]   req,
  output logic [REQ_NUM-1:0]              resp_valid,
  input  logic [REQ_NUM-1:0]              resp_ready,
  output logic [RES_W-1:0]                resp,
  input  logic                            flush,
  input  logic                            tlb_write_busy,
  output logic [REQ_W-1:0]                tlb_search,
  input  logic [RES_W-1:0]                tlb_result
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] OWN_CP0  = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  state_t           state_p1;
  state_t           state_nxt;
  logic [1:0]       owner_p1;
  logic [RES_W-1:0] result_p1;
  logic             rr_ptr_p1;

  logic             owner_ready;
  logic             owner_accept;
  logic             owner_flushed;
  logic             slot_free;
  logic             grant_en;
  logic             elig_inst;
  logic             elig_data;
  logic             has_winner;
  logic [1:0]       winner;
  logic             grant;

  // Select the resp_ready bit of the current owner. Bits of other requesters
  // are ignored.
  always_comb begin
    owner_ready = 1'b0;
    case (owner_p1)
      OWN_CP0:  owner_ready = resp_ready[0];
      OWN_INST: owner_ready = resp_ready[1];
      OWN_DATA: owner_ready = resp_ready[2];
      default:  owner_ready = 1'b0;
    endcase
  end

  assign owner_accept  = (state_p1 == HOLD) && owner_ready;
  assign owner_flushed = (state_p1 == HOLD) && flush && (owner_p1 != OWN_CP0);

  // The slot can be refilled in the same cycle the owner accepts. This is the
  // combinational path from resp_ready to req_ready. Reset gates grants so
  // that req_ready stays low while reset is asserted.
  assign slot_free = (state_p1 == IDLE) || owner_accept;
  assign grant_en  = slot_free && !tlb_write_busy && !reset;

  assign elig_inst = req_valid[1] && !flush;
  assign elig_data = req_valid[2] && !flush;

  // Winner selection: cp0 always wins. inst and data alternate on a tie
  // (rr_ptr 0 favours inst). A lone requester wins regardless of rr_ptr.
  always_comb begin
    has_winner = 1'b1;
    winner     = OWN_CP0;
    if (req_valid[0]) begin
      winner = OWN_CP0;
    end else if (elig_inst && elig_data) begin
      winner = rr_ptr_p1 ? OWN_DATA : OWN_INST;
    end else if (elig_inst) begin
      winner = OWN_INST;
    end else if (elig_data) begin
      winner = OWN_DATA;
    end else begin
      has_winner = 1'b0;
    end
  end

  assign grant = grant_en && has_winner;

  // Steer the winner's request to the TLB. With no winner the port carries
  // req[0], and the TLB result is then ignored.
  always_comb begin
    case (winner)
      OWN_INST: tlb_search = req[1];
      OWN_DATA: tlb_search = req[2];
      default:  tlb_search = req[0];
    endcase
  end

  // ---- stage p1: FSM state register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p1 <= IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Next-state logic. A new grant takes priority, so an accept and a grant
  // in the same cycle keep the FSM in HOLD with the new owner.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE: begin
        if (grant) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (grant) begin
          state_nxt = HOLD;
        end else if (owner_accept || owner_flushed) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: owner, held result and round-robin pointer ----
  // The held result is cleared by reset so that resp reads zero immediately,
  // even while the FSM is in HOLD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_p1  <= OWN_CP0;
      result_p1 <= '0;
      rr_ptr_p1 <= 1'b0;
    end else if (grant) begin
      owner_p1  <= winner;
      result_p1 <= tlb_result;
      if (winner == OWN_INST) begin
        rr_ptr_p1 <= 1'b1;
      end else if (winner == OWN_DATA) begin
        rr_ptr_p1 <= 1'b0;
      end
    end
  end

  // Outputs. resp_valid comes only from registered state, so resp_ready has
  // no combinational path to it.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (grant) begin
      case (winner)
        OWN_INST: req_ready[1] = 1'b1;
        OWN_DATA: req_ready[2] = 1'b1;
        default:  req_ready[0] = 1'b1;
      endcase
    end
    if (state_p1 == HOLD) begin
      case (owner_p1)
        OWN_CP0:  resp_valid[0] = 1'b1;
        OWN_INST: resp_valid[1] = 1'b1;
        OWN_DATA: resp_valid[2] = 1'b1;
        default:  resp_valid    = '0;
      endcase
    end
  end

  assign resp = result_p1;

endmodule

// File: tb/tb_tlb_search_arbiter.sv
module tb_tlb_search_arbiter;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [2:0][27:0]  req;
  logic [2:0]        resp_valid;
  logic [2:0]        resp_ready;
  logic [29:0]       resp;
  logic              flush;
  logic              tlb_write_busy;
  logic [27:0]       tlb_search;
  logic [29:0]       tlb_result;

  int errors = 0;
  int checks = 0;

  localparam logic [27:0] REQ0  = {19'h00010, 1'b0, 8'h05};
  localparam logic [27:0] REQ1  = {19'h00020, 1'b1, 8'h05};
  localparam logic [27:0] REQ2  = {19'h00030, 1'b0, 8'h07};
  localparam logic [27:0] REQM  = {19'h7FFFF, 1'b0, 8'h01};
  localparam logic [29:0] RES0  = {1'b1, 4'h3, 25'h00ABCDE};
  localparam logic [29:0] RES1  = {1'b1, 4'h7, 25'h0123456};
  localparam logic [29:0] RES2  = {1'b1, 4'h9, 25'h1FEDCBA};

  always #5 clock = ~clock;

  tlb_search_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req            (req),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp           (resp),
    .flush          (flush),
    .tlb_write_busy (tlb_write_busy),
    .tlb_search     (tlb_search),
    .tlb_result     (tlb_result)
  );

  // TLB model: three mapped pages. The odd-page bit is ignored.
  always_comb begin
    tlb_result = '0;
    if (tlb_search[27:9] == 19'h00010 && tlb_search[7:0] == 8'h05)
      tlb_result = RES0;
    else if (tlb_search[27:9] == 19'h00020 && tlb_search[7:0] == 8'h05)
      tlb_result = RES1;
    else if (tlb_search[27:9] == 19'h00030 && tlb_search[7:0] == 8'h07)
      tlb_result = RES2;
  end

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    flush = 1'b0;
    tlb_write_busy = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 3'b111;
    resp_ready = 3'b111;
    flush = 1'b0;
    tlb_write_busy = 1'b0;
    @(posedge clock);
    #2;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL rst_ready: got %b want %b", req_ready, 3'b000);
    end
    checks++;
    if (resp_valid !== 3'b000) begin
      errors++; $display("FAIL rst_resp_valid: got %b want %b", resp_valid, 3'b000);
    end
    checks++;
    if (resp !== 30'h0) begin
      errors++; $display("FAIL rst_resp: got %h want %h", resp, 30'h0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b000) begin
      errors++; $display("FAIL rst_after_resp_valid: got %b want %b", resp_valid, 3'b000);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ready;
    logic [2:0]  prev_ready;
    logic [27:0] exp_search;
    logic [29:0] prev_res;
    do_reset();
    req_valid = 3'b110;
    resp_ready = 3'b111;
    prev_ready = 3'b000;
    prev_res = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      #1;
      exp_ready  = (i % 2 == 0) ? 3'b010 : 3'b100;
      exp_search = (i % 2 == 0) ? REQ1 : REQ2;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_ready c%0d: got %b want %b", i, req_ready, exp_ready);
      end
      checks++;
      if (tlb_search !== exp_search) begin
        errors++; $display("FAIL rr_search c%0d: got %h want %h", i, tlb_search, exp_search);
      end
      checks++;
      if (resp_valid !== prev_ready) begin
        errors++; $display("FAIL rr_resp_valid c%0d: got %b want %b", i, resp_valid, prev_ready);
      end
      if (i > 0) begin
        checks++;
        if (resp !== prev_res) begin
          errors++; $display("FAIL rr_resp c%0d: got %h want %h", i, resp, prev_res);
        end
      end
      prev_ready = exp_ready;
      prev_res = (i % 2 == 0) ? RES1 : RES2;
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b100) begin
      errors++; $display("FAIL rr_tail_resp_valid: got %b want %b", resp_valid, 3'b100);
    end
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL rr_tail_ready: got %b want %b", req_ready, 3'b000);
    end
    next_cycle();
    #1;
    checks++;
    if (resp_valid !== 3'b000) begin
      errors++; $display("FAIL rr_idle_resp_valid: got %b want %b", resp_valid, 3'b000);
    end
  endtask

  task automatic test_cp0_priority();
    do_reset();
    req_valid = 3'b111;
    resp_ready = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL cp0_ready: got %b want %b", req_ready, 3'b001);
    end
    checks++;
    if (tlb_search !== REQ0) begin
      errors++; $display("FAIL cp0_search: got %h want %h", tlb_search, REQ0);
    end
    next_cycle();
    req_valid = 3'b110;
    #1;
    checks++;
    if (resp_valid !== 3'b001) begin
      errors++; $display("FAIL cp0_resp_valid: got %b want %b", resp_valid, 3'b001);
    end
    checks++;
    if (resp[29] !== 1'b1) begin
      errors++; $display("FAIL cp0_found: got %b want %b", resp[29], 1'b1);
    end
    checks++;
    if (resp[28:25] !== 4'h3) begin
      errors++; $display("FAIL cp0_index: got %h want %h", resp[28:25], 4'h3);
    end
    checks++;
    if (resp !== RES0) begin
      errors++; $display("FAIL cp0_resp: got %h want %h", resp, RES0);
    end
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL cp0_next_tie: got %b want %b", req_ready, 3'b010);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b010) begin
      errors++; $display("FAIL cp0_then_inst: got %b want %b", resp_valid, 3'b010);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 3'b100;
    resp_ready = 3'b011;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL bp_grant: got %b want %b", req_ready, 3'b100);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      req_valid = 3'b010;
      #1;
      checks++;
      if (resp_valid !== 3'b100) begin
        errors++; $display("FAIL bp_resp_valid c%0d: got %b want %b", i, resp_valid, 3'b100);
      end
      checks++;
      if (resp !== RES2) begin
        errors++; $display("FAIL bp_resp c%0d: got %h want %h", i, resp, RES2);
      end
      checks++;
      if (req_ready !== 3'b000) begin
        errors++; $display("FAIL bp_ready c%0d: got %b want %b", i, req_ready, 3'b000);
      end
    end
    next_cycle();
    resp_ready = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL bp_pass_ready: got %b want %b", req_ready, 3'b010);
    end
    checks++;
    if (resp_valid !== 3'b100) begin
      errors++; $display("FAIL bp_accept_valid: got %b want %b", resp_valid, 3'b100);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b010) begin
      errors++; $display("FAIL bp_new_owner: got %b want %b", resp_valid, 3'b010);
    end
    checks++;
    if (resp !== RES1) begin
      errors++; $display("FAIL bp_new_resp: got %h want %h", resp, RES1);
    end
  endtask

  task automatic test_write_busy();
    do_reset();
    tlb_write_busy = 1'b1;
    req_valid = 3'b111;
    resp_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++; $display("FAIL busy_ready c%0d: got %b want %b", i, req_ready, 3'b000);
      end
      checks++;
      if (resp_valid !== 3'b000) begin
        errors++; $display("FAIL busy_resp_valid c%0d: got %b want %b", i, resp_valid, 3'b000);
      end
    end
    next_cycle();
    tlb_write_busy = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL busy_release: got %b want %b", req_ready, 3'b001);
    end
    next_cycle();
    req_valid = 3'b000;
    resp_ready = 3'b000;
    tlb_write_busy = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 3'b001 || resp !== RES0) begin
      errors++; $display("FAIL busy_hold: got %b/%h want %b/%h", resp_valid, resp, 3'b001, RES0);
    end
    next_cycle();
    #1;
    checks++;
    if (resp_valid !== 3'b001) begin
      errors++; $display("FAIL busy_kept: got %b want %b", resp_valid, 3'b001);
    end
    tlb_write_busy = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 3'b010;
    resp_ready = 3'b000;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL fl_grant: got %b want %b", req_ready, 3'b010);
    end
    next_cycle();
    req_valid = 3'b000;
    flush = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 3'b010 || resp !== RES1) begin
      errors++; $display("FAIL fl_held: got %b/%h want %b/%h", resp_valid, resp, 3'b010, RES1);
    end
    next_cycle();
    req_valid = 3'b011;
    #1;
    checks++;
    if (resp_valid !== 3'b000) begin
      errors++; $display("FAIL fl_dropped: got %b want %b", resp_valid, 3'b000);
    end
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL fl_cp0_only: got %b want %b", req_ready, 3'b001);
    end
    next_cycle();
    req_valid = 3'b110;
    #1;
    checks++;
    if (resp_valid !== 3'b001) begin
      errors++; $display("FAIL fl_cp0_kept: got %b want %b", resp_valid, 3'b001);
    end
    next_cycle();
    resp_ready = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL fl_no_inst_data: got %b want %b", req_ready, 3'b000);
    end
    checks++;
    if (resp_valid !== 3'b001) begin
      errors++; $display("FAIL fl_cp0_still: got %b want %b", resp_valid, 3'b001);
    end
    next_cycle();
    resp_ready = 3'b000;
    req_valid = 3'b000;
    flush = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 3'b000) begin
      errors++; $display("FAIL fl_idle: got %b want %b", resp_valid, 3'b000);
    end
  endtask

  task automatic test_miss();
    do_reset();
    req[1] = REQM;
    req_valid = 3'b010;
    resp_ready = 3'b111;
    next_cycle();
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b010 || resp !== 30'h0) begin
      errors++; $display("FAIL miss_resp: got %b/%h want %b/%h", resp_valid, resp, 3'b010, 30'h0);
    end
    req[1] = REQ1;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    req_valid = 3'b100;
    resp_ready = 3'b000;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL rh_grant: got %b want %b", req_ready, 3'b100);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b100) begin
      errors++; $display("FAIL rh_held: got %b want %b", resp_valid, 3'b100);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 3'b000) begin
      errors++; $display("FAIL rh_async_valid: got %b want %b", resp_valid, 3'b000);
    end
    checks++;
    if (resp !== 30'h0) begin
      errors++; $display("FAIL rh_async_resp: got %h want %h", resp, 30'h0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    req_valid = 3'b110;
    resp_ready = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL rh_first_tie: got %b want %b", req_ready, 3'b010);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    checks++;
    if (resp_valid !== 3'b010) begin
      errors++; $display("FAIL rh_inst_resp: got %b want %b", resp_valid, 3'b010);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    flush = 1'b0;
    tlb_write_busy = 1'b0;
    req[0] = REQ0;
    req[1] = REQ1;
    req[2] = REQ2;
    test_reset();
    test_round_robin();
    test_cp0_priority();
    test_backpressure();
    test_write_busy();
    test_flush();
    test_miss();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
